mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shares one single-ported memory between the instruction-fetch requester (IM side) and the data requester (DM side) of the multi-cycle core. Each side uses a req/ack handshake. A small FSM serialises the accesses, uses round-robin priority on ties, and applies a fixed memory latency. It sits between the core controller/datapath and a unified SRAM, in place of separate IM and DM macros.

Parameters:
ADDR_WIDTH, 32, width of all address buses
DATA_WIDTH, 32, width of all data buses
LATENCY, 2, number of memory access cycles per transaction (legal range 1..15)

Ports:
clock  in  1  system clock; all state updates on its rising edge
reset  in  1  synchronous, active-low reset, sampled on the rising edge of clock
im_req  in  1  instruction fetch request (read only); held until im_ack
im_address  in  ADDR_WIDTH  fetch address
im_ack  out  1  one-cycle completion pulse to the IM side
im_rdata  out  DATA_WIDTH  fetched word
dm_req  in  1  data request; held until dm_ack
dm_write  in  1  1 = write, 0 = read; qualifies dm_req
dm_address  in  ADDR_WIDTH  data address
dm_wdata  in  DATA_WIDTH  write data
dm_ack  out  1  one-cycle completion pulse to the DM side
dm_rdata  out  DATA_WIDTH  load data
mem_enable  out  1  memory chip enable
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_address  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_rdata  in  DATA_WIDTH  memory read data
busy  out  1  high whenever the FSM is not in IDLE
grant_dm  out  1  owner of the current or last transaction (0 = IM, 1 = DM)

Behaviour:
- Reset (reset == 0 at the clock edge):
  - State goes to IDLE; counter = 0; last_grant = DM.
  - All outputs are 0, including both rdata registers and the latched address/wdata.
  - Reset wins over every other event. An in-flight access is abandoned, and no ack is issued for it.
- States: IDLE, ACCESS, DONE. Encoding is free.
- IDLE:
  - No req: remain in IDLE.
  - One req: grant that side.
  - Both reqs: grant the side that is not last_grant. The first tie after reset therefore goes to IM.
  - On grant: latch address, wdata, write (IM is always read) and grant_dm. Load the counter with LATENCY-1. Go to ACCESS.
- ACCESS:
  - mem_enable = 1 throughout.
  - mem_read = !latched_write and mem_write = latched_write, held for every ACCESS cycle.
  - mem_address and mem_wdata come from the latched registers.
  - The counter decrements each cycle.
  - When the counter reaches 0: for reads, capture mem_rdata into the granted side's rdata register; then go to DONE.
- DONE:
  - Strobes are 0.
  - The granted side's ack is high for exactly this one cycle; the other ack stays 0.
  - last_grant is set to the granted side.
  - Next state is IDLE.
- Timing:
  - A req sampled in IDLE at edge N produces ACCESS cycles N+1..N+LATENCY and ack in cycle N+LATENCY+1.
  - A transaction occupies LATENCY+2 cycles.
- rdata holding: im_rdata and dm_rdata are valid from ack onward. Each holds until the next read completion for its own side. A DM write never changes dm_rdata.
- Requester rules:
  - The requester drops req in the cycle after it sees ack.
  - A req still high in the following IDLE cycle counts as a new request (back-to-back).
  - Dropping req mid-transaction is ignored: the access completes and ack still pulses.
  - Address/data changes after the grant are ignored.
- Fairness: with both reqs continuously high, grants alternate IM, DM, IM, ..., so neither side starves.
- mem_address and mem_wdata always show the latched values. Only mem_enable, mem_read and mem_write are qualified by state.
- busy = (state != IDLE). grant_dm is updated at grant time.

Test Plan:
1. Reset: hold reset = 0 for 3 cycles with both reqs high. Required: all outputs 0, busy = 0. After release, the first grant goes to IM (grant_dm = 0).
2. Single fetch, LATENCY = 2: im_req with im_address = 0x40 and mem_rdata = 0xDEADBEEF. Required: mem_read high for 2 cycles with mem_address = 0x40; im_ack pulses 3 cycles after the req is sampled; im_rdata = 0xDEADBEEF; dm_ack stays 0.
3. DM write: dm_write = 1, dm_address = 0x100, dm_wdata = 0x12345678. Required: mem_write high for LATENCY cycles with address 0x100 and data 0x12345678; mem_read = 0; dm_ack pulses once; dm_rdata is unchanged.
4. Contention: im_req and dm_req both held high for 4 transactions. Required: grant order IM, DM, IM, DM; each ack pulses exactly once per transaction; 4 × (LATENCY+2) cycles in total.
5. Abort: assert reset = 0 in the 2nd ACCESS cycle of a DM read. Required: no dm_ack; state returns to IDLE; dm_rdata = 0. The next tie goes to IM.
6. Req drop: deassert im_req and change im_address to 0x80 in the first ACCESS cycle. Required: the access to the original address completes, im_ack pulses, and no second transaction starts.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: lets the instruction-fetch (IM) and data (DM) requesters of the
// multi-cycle core share one single-ported SRAM. Accesses are serialised by a
// small IDLE -> ACCESS -> DONE FSM. Simultaneous requests are granted
// round-robin, and every access lasts a fixed LATENCY cycles.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 2     // memory access cycles, 1..15
) (
    input  logic                  clock,
    input  logic                  reset,
    // instruction-fetch side (read only)
    input  logic                  im_req,
    input  logic [ADDR_WIDTH-1:0] im_address,
    output logic                  im_ack,
    output logic [DATA_WIDTH-1:0] im_rdata,
    // data side
    input  logic                  dm_req,
    input  logic                  dm_write,
    input  logic [ADDR_WIDTH-1:0] dm_address,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic                  dm_ack,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    // unified memory
    output logic                  mem_enable,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    // status
    output logic                  busy,
    output logic                  grant_dm
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // The counter is loaded at grant time and hits zero in the last ACCESS cycle.
    localparam logic [3:0] COUNT_LOAD = 4'(LATENCY - 1);

    state_t                  state;
    state_t                  state_next;
    logic [3:0]              counter;
    logic                    last_grant;     // 1 = DM owned the last completed access
    logic                    grant_valid;
    logic                    grant_side;     // 1 = DM wins this arbitration
    logic                    latched_write;
    logic [ADDR_WIDTH-1:0]   latched_address;
    logic [DATA_WIDTH-1:0]   latched_wdata;

    // Pick a winner. A tie goes to the side that did not own the last access.
    always_comb begin
        grant_valid = im_req | dm_req;
        grant_side  = (im_req & dm_req) ? ~last_grant : dm_req;
    end

    // State register.
    always_ff @(posedge clock) begin
        // NOTE: reset is synchronous, so it is tested inside the clocked block and is not in the sensitivity list.
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the state-qualified strobes and acks.
    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case can leave one unassigned and infer a latch.
        state_next = state;
        mem_enable = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        im_ack     = 1'b0;
        dm_ack     = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid) state_next = ACCESS;
            end
            ACCESS: begin
                mem_enable = 1'b1;
                mem_read   = ~latched_write;
                mem_write  = latched_write;
                if (counter == 4'd0) state_next = DONE;
            end
            DONE: begin
                im_ack     = ~grant_dm;
                dm_ack     = grant_dm;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Grant latching, latency counter, read-data capture and round-robin history.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments ensure every register here samples pre-edge values, independent of statement order.
        if (!reset) begin
            counter         <= 4'd0;
            last_grant      <= 1'b1;
            grant_dm        <= 1'b0;
            latched_write   <= 1'b0;
            latched_address <= '0;
            latched_wdata   <= '0;
            im_rdata        <= '0;
            dm_rdata        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        grant_dm        <= grant_side;
                        latched_write   <= grant_side & dm_write;
                        latched_address <= grant_side ? dm_address : im_address;
                        // IM has no write data, so the latch holds zero for fetches.
                        latched_wdata   <= grant_side ? dm_wdata : '0;
                        counter         <= COUNT_LOAD;
                    end
                end
                ACCESS: begin
                    if (counter == 4'd0) begin
                        if (!latched_write) begin
                            if (grant_dm) dm_rdata <= mem_rdata;
                            else          im_rdata <= mem_rdata;
                        end
                    end else begin
                        counter <= counter - 4'd1;
                    end
                end
                DONE: begin
                    last_grant <= grant_dm;
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state != IDLE);
    assign mem_address = latched_address;
    assign mem_wdata   = latched_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios followed by a randomized phase. A
// transaction-level reference model predicts every output on every cycle.
// Memory contents come from a hash of the address plus any writes.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int L  = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          im_req, dm_req, dm_write;
    logic [AW-1:0] im_address, dm_address;
    logic [DW-1:0] dm_wdata, mem_rdata;
    logic          im_ack, dm_ack, mem_enable, mem_read, mem_write, busy, grant_dm;
    logic [DW-1:0] im_rdata, dm_rdata, mem_wdata;
    logic [AW-1:0] mem_address;

    always #5 clock = ~clock;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LATENCY(L)) dut (
        .clock(clock), .reset(reset),
        .im_req(im_req), .im_address(im_address), .im_ack(im_ack), .im_rdata(im_rdata),
        .dm_req(dm_req), .dm_write(dm_write), .dm_address(dm_address), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .mem_enable(mem_enable), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .grant_dm(grant_dm)
    );

    int errors = 0;
    int checks = 0;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory contents: a fixed hash of the address unless overwritten.
    function automatic logic [31:0] base_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
    endfunction

    logic [31:0] env_mem   [logic [31:0]];   // what the DUT actually wrote
    logic [31:0] model_mem [logic [31:0]];   // what the model expects to be stored

    function automatic logic [31:0] env_read(input logic [31:0] a);
        return env_mem.exists(a) ? env_mem[a] : base_word(a);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : base_word(a);
    endfunction

    // Reference model. A transaction is a timeline: position 1..L is the
    // access window and position L+1 is the ack cycle.
    bit          m_active, m_side, m_write, m_last, m_grant_dm;
    int          m_pos;
    logic [31:0] m_addr, m_wdata, m_im_rdata, m_dm_rdata;

    task automatic model_clock();
        if (!reset) begin
            m_active = 0; m_side = 0; m_write = 0; m_last = 1; m_grant_dm = 0;
            m_pos = 0; m_addr = 0; m_wdata = 0; m_im_rdata = 0; m_dm_rdata = 0;
        end else if (!m_active) begin
            if (im_req || dm_req) begin
                m_side     = (im_req && dm_req) ? !m_last : dm_req;
                m_active   = 1;
                m_pos      = 1;
                m_grant_dm = m_side;
                m_write    = m_side && dm_write;
                m_addr     = m_side ? dm_address : im_address;
                m_wdata    = m_side ? dm_wdata : 32'h0;
            end
        end else if (m_pos == L + 1) begin
            m_active = 0;
            m_last   = m_side;
        end else begin
            if (m_pos == L) begin
                if (m_write)     model_mem[m_addr] = m_wdata;
                else if (m_side) m_dm_rdata = model_read(m_addr);
                else             m_im_rdata = model_read(m_addr);
            end
            m_pos++;
        end
    endtask

    int im_acks = 0, dm_acks = 0, rd_cycles = 0, wr_cycles = 0;

    task automatic compare_all();
        bit acc, done;
        acc  = m_active && (m_pos <= L);
        done = m_active && (m_pos == L + 1);
        check_bit ("busy",        busy,        m_active);
        check_bit ("grant_dm",    grant_dm,    m_grant_dm);
        check_bit ("mem_enable",  mem_enable,  acc);
        check_bit ("mem_read",    mem_read,    acc && !m_write);
        check_bit ("mem_write",   mem_write,   acc && m_write);
        check_bit ("im_ack",      im_ack,      done && !m_side);
        check_bit ("dm_ack",      dm_ack,      done && m_side);
        check_word("mem_address", mem_address, m_addr);
        check_word("mem_wdata",   mem_wdata,   m_wdata);
        check_word("im_rdata",    im_rdata,    m_im_rdata);
        check_word("dm_rdata",    dm_rdata,    m_dm_rdata);
    endtask

    // One clock: the memory responds, the model advances, and outputs are
    // compared on the falling edge.
    task automatic step();
        if (mem_write === 1'b1) env_mem[mem_address] = mem_wdata;
        mem_rdata = env_read(mem_address);
        model_clock();
        @(posedge clock);
        @(negedge clock);
        compare_all();
        if (im_ack === 1'b1)    im_acks++;
        if (dm_ack === 1'b1)    dm_acks++;
        if (mem_read === 1'b1)  rd_cycles++;
        if (mem_write === 1'b1) wr_cycles++;
    endtask

    // Step until the requested side acks, within a bounded number of cycles.
    task automatic run_until_ack(input bit side, output int n);
        logic got;
        got = 1'b0;
        n   = 0;
        while (!got && n < 20) begin
            step();
            n++;
            got = side ? dm_ack : im_ack;
        end
        check_bit(side ? "dm_ack_timeout" : "im_ack_timeout", got, 1'b1);
    endtask

    int n, a0, d0, r0, w0;
    logic g [4];

    initial begin
        reset = 1'b0; im_req = 0; dm_req = 0; dm_write = 0;
        im_address = 0; dm_address = 0; dm_wdata = 0; mem_rdata = 0;
        env_mem[32'h40]   = 32'hDEAD_BEEF;
        model_mem[32'h40] = 32'hDEAD_BEEF;
        @(negedge clock);

        // 1. Reset held with both requests high, then the first tie goes to IM.
        im_req = 1; dm_req = 1;
        repeat (3) step();
        check_bit ("t1_busy",     busy,     1'b0);
        check_word("t1_im_rdata", im_rdata, 32'h0);
        check_word("t1_dm_rdata", dm_rdata, 32'h0);
        reset = 1'b1;
        step();
        check_bit("t1_first_grant_im", grant_dm, 1'b0);
        check_bit("t1_busy_after",     busy,     1'b1);
        im_req = 0; dm_req = 0;
        run_until_ack(1'b0, n);
        step();

        // 2. Single fetch from 0x40.
        a0 = im_acks; d0 = dm_acks; r0 = rd_cycles;
        im_req = 1; im_address = 32'h40;
        run_until_ack(1'b0, n);
        im_req = 0;
        check_word("t2_ack_latency", n, L + 1);
        check_word("t2_read_cycles", rd_cycles - r0, L);
        check_word("t2_im_rdata",    im_rdata, 32'hDEAD_BEEF);
        step();
        check_word("t2_im_acks", im_acks - a0, 1);
        check_word("t2_dm_acks", dm_acks - d0, 0);

        // 3. DM write to 0x100.
        d0 = dm_acks; r0 = rd_cycles; w0 = wr_cycles;
        dm_req = 1; dm_write = 1; dm_address = 32'h100; dm_wdata = 32'h1234_5678;
        step();
        check_word("t3_mem_address", mem_address, 32'h100);
        check_word("t3_mem_wdata",   mem_wdata,   32'h1234_5678);
        run_until_ack(1'b1, n);
        dm_req = 0; dm_write = 0;
        step();
        check_word("t3_write_cycles", wr_cycles - w0, L);
        check_word("t3_read_cycles",  rd_cycles - r0, 0);
        check_word("t3_dm_acks",      dm_acks - d0, 1);
        check_word("t3_dm_rdata",     dm_rdata, 32'h0);

        // 4. Contention: both requests held for four transactions.
        a0 = im_acks; d0 = dm_acks;
        im_req = 1; im_address = 32'h48; dm_req = 1; dm_write = 0; dm_address = 32'h100;
        for (int t = 0; t < 4; t++) begin
            step();
            g[t] = grant_dm;
            repeat (L + 1) step();
        end
        im_req = 0; dm_req = 0;
        check_bit ("t4_grant0", g[0], 1'b0);
        check_bit ("t4_grant1", g[1], 1'b1);
        check_bit ("t4_grant2", g[2], 1'b0);
        check_bit ("t4_grant3", g[3], 1'b1);
        check_word("t4_im_acks", im_acks - a0, 2);
        check_word("t4_dm_acks", dm_acks - d0, 2);
        check_bit ("t4_idle_after_16", busy, 1'b0);
        check_word("t4_dm_rdata", dm_rdata, 32'h1234_5678);

        // 5. Reset during the second ACCESS cycle of a DM read.
        d0 = dm_acks;
        dm_req = 1; dm_write = 0; dm_address = 32'h200;
        step();
        step();
        reset = 1'b0;
        step();
        check_bit ("t5_busy",     busy,     1'b0);
        check_word("t5_dm_rdata", dm_rdata, 32'h0);
        reset = 1'b1; im_req = 1; im_address = 32'h4C;
        step();
        check_bit ("t5_tie_to_im", grant_dm, 1'b0);
        im_req = 0; dm_req = 0;
        run_until_ack(1'b0, n);
        step();
        check_word("t5_no_dm_ack", dm_acks - d0, 0);

        // 6. Request dropped and address changed in the first ACCESS cycle.
        a0 = im_acks;
        im_req = 1; im_address = 32'h44;
        step();
        im_req = 0; im_address = 32'h80;
        run_until_ack(1'b0, n);
        check_word("t6_im_rdata", im_rdata, base_word(32'h44));
        repeat (2) step();
        check_bit ("t6_no_restart", busy, 1'b0);
        check_word("t6_im_acks",    im_acks - a0, 1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            reset      = ($urandom_range(79) != 0);
            im_req     = $urandom_range(1);
            dm_req     = $urandom_range(1);
            dm_write   = $urandom_range(1);
            im_address = 32'($urandom_range(15)) << 2;
            dm_address = 32'($urandom_range(15)) << 2;
            dm_wdata   = $urandom;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
